voice_sequencer: RTL and testbench



---
 rtl/voice_seq_pkg.sv | 19 +
 rtl/voice_phase_bank.sv | 30 +++
 rtl/voice_sequencer.sv | 166 ++++++++++++++++
 tb/tb_voice_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_seq_pkg.sv
// Shared types and helpers for the voice sequencer: FSM state encoding and a
// ceiling-log2 used to size indices, counters and the mix accumulator.
package voice_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice phase accumulator storage: one combinational read port selected by
// voice index, one write port used for both the phase update and the clear.
module voice_phase_bank
  import voice_seq_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 22
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [log2_ceil(NUM_VOICES)-1:0]      rd_idx,
  output logic [PHASE_W-1:0]                    rd_phase,
  input  logic                                  wr_en,
  input  logic [log2_ceil(NUM_VOICES)-1:0]      wr_idx,
  input  logic [PHASE_W-1:0]                    wr_data
);

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else if (wr_en) begin
      phase_q[wr_idx] <= wr_data;
    end
  end

  assign rd_phase = phase_q[rd_idx];

endmodule

// File: rtl/voice_sequencer.sv
// Walks NUM_VOICES voices through one shared sine ROM per codec frame and emits
// the mixed sample. Build option VOICE_SEQ_SATURATE_EN: saturate instead of divide.
module voice_sequencer
  import voice_seq_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 22,
  parameter int STEP_W     = 20,
  parameter int ADDR_W     = 10,
  parameter int ROM_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_frame,
  input  logic [NUM_VOICES-1:0]        voice_en,
  input  logic [NUM_VOICES*STEP_W-1:0] step_size,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic                         rom_req,
  input  logic [15:0]                  rom_data,
  output logic [15:0]                  sample_out,
  output logic                         new_sample_generated,
  output logic                         busy,
  output logic                         overrun
);

  localparam int LOG2V = log2_ceil(NUM_VOICES);
  localparam int ACC_W = 16 + LOG2V;
  localparam int LAT_W = log2_ceil(ROM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);
  localparam logic [LOG2V-1:0] V_LAST   = LOG2V'(NUM_VOICES - 1);

  // Mix-down of the accumulator to the 16-bit output sample.
  function automatic logic signed [15:0] scale_sample(input logic signed [ACC_W-1:0] a);
`ifdef VOICE_SEQ_SATURATE_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(LOG2V+1){1'b0}}, {15{1'b1}}};
    sat_min = {{(LOG2V+1){1'b1}}, {15{1'b0}}};
    if (a > sat_max)      return 16'sh7FFF;
    else if (a < sat_min) return 16'sh8000;
    else                  return a[15:0];
`else
    logic signed [ACC_W-1:0] sh;
    sh = a >>> LOG2V;
    return sh[15:0];
`endif
  endfunction

  state_t                   state_q, state_d;
  logic [LOG2V-1:0]         v_q, v_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic signed [15:0]       sample_q, sample_d;
  logic                     overrun_q;
  logic [PHASE_W-1:0]       rd_phase;
  logic                     wr_en;
  logic [PHASE_W-1:0]       wr_data;
  logic signed [ACC_W-1:0]  rom_sext;

  voice_phase_bank #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_phase_bank (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (v_q),
    .rd_phase (rd_phase),
    .wr_en    (wr_en),
    .wr_idx   (v_q),
    .wr_data  (wr_data)
  );

  assign rom_sext = $signed({{LOG2V{rom_data[15]}}, rom_data});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      v_q       <= '0;
      lat_q     <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      lat_q    <= lat_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      sample_q <= sample_d;
      // A frame request that lands while a sequence (including DONE) is running is dropped.
      if (new_frame && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    state_d              = state_q;
    v_d                  = v_q;
    lat_d                = lat_q;
    acc_d                = acc_q;
    step_d               = step_q;
    sample_d             = sample_q;
    wr_en                = 1'b0;
    wr_data              = '0;
    rom_req              = 1'b0;
    rom_addr             = '0;
    new_sample_generated = 1'b0;
    busy                 = 1'b0;
    sample_out           = sample_q;
    unique case (state_q)
      IDLE: begin
        if (new_frame) begin
          acc_d   = '0;
          v_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (voice_en[v_q]) begin
          rom_req  = 1'b1;
          rom_addr = rd_phase[PHASE_W-1 -: ADDR_W];
          step_d   = step_size[int'(v_q)*STEP_W +: STEP_W];
          lat_d    = '0;
          state_d  = WAIT;
        end else begin
          // Disabled voices restart from phase 0 when re-enabled.
          wr_en = 1'b1;
          if (v_q == V_LAST) begin
            state_d = DONE;
          end else begin
            v_d     = v_q + LOG2V'(1);
            state_d = ISSUE;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_q == LAT_LAST) begin
          acc_d   = acc_q + rom_sext;
          wr_en   = 1'b1;
          wr_data = rd_phase + PHASE_W'(step_q);
          if (v_q == V_LAST) begin
            state_d = DONE;
          end else begin
            v_d     = v_q + LOG2V'(1);
            state_d = ISSUE;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DONE: begin
        new_sample_generated = 1'b1;
        sample_d             = scale_sample(acc_q);
        sample_out           = sample_d;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with a one-cycle-latency ROM model that
// returns either its address or a forced constant.
module tb_voice_sequencer;

  localparam int NV = 4;
  localparam int PW = 22;
  localparam int SW = 20;
  localparam int AW = 10;
  localparam int LAT = 1;
`ifdef VOICE_SEQ_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [15:0] CH_VAL  [4] = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFFFE};
  localparam logic [15:0] CH_SHF  [4] = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFFFE};
  localparam logic [15:0] CH_SATV [4] = '{16'h7FFF, 16'h8000, 16'h0400, 16'hFFF8};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic new_frame = 1'b0;
  logic [NV-1:0] voice_en = '0;
  logic [NV*SW-1:0] step_size = '0;
  logic [AW-1:0] rom_addr;
  logic rom_req;
  logic [15:0] rom_data = '0;
  logic [15:0] sample_out;
  logic new_sample_generated;
  logic busy;
  logic overrun;

  int n_cmp = 0;
  int n_bad = 0;

  bit rom_const_mode = 1'b0;
  logic [15:0] rom_const = '0;

  int pulse_cyc;
  logic [15:0] samp;
  int req_cnt;
  logic [AW-1:0] req_addr [0:7];
  logic busy_c1;

  voice_sequencer #(
    .NUM_VOICES (NV),
    .PHASE_W    (PW),
    .STEP_W     (SW),
    .ADDR_W     (AW),
    .ROM_LAT    (LAT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .new_frame            (new_frame),
    .voice_en             (voice_en),
    .step_size            (step_size),
    .rom_addr             (rom_addr),
    .rom_req              (rom_req),
    .rom_data             (rom_data),
    .sample_out           (sample_out),
    .new_sample_generated (new_sample_generated),
    .busy                 (busy),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_const_mode ? rom_const : {6'b0, rom_addr};

  // Pulses new_frame in cycle 0 and observes cycles 1..20 until the sample pulse.
  task automatic run_frame(input int inject_at);
    @(posedge clk); #1 new_frame = 1'b1;
    @(posedge clk); #1 new_frame = 1'b0;
    pulse_cyc = -1;
    samp = '0;
    req_cnt = 0;
    busy_c1 = 1'b0;
    for (int c = 1; c <= 20 && pulse_cyc < 0; c++) begin
      if (c == inject_at) new_frame = 1'b1;
      @(negedge clk);
      if (c == 1) busy_c1 = busy;
      if (rom_req) begin
        if (req_cnt < 8) req_addr[req_cnt] = rom_addr;
        req_cnt++;
      end
      if (new_sample_generated) begin
        pulse_cyc = c;
        samp = sample_out;
      end
      @(posedge clk); #1 new_frame = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_addr !== '0) begin n_bad++; $display("FAIL rst_rom_addr: got %h want 0", rom_addr); end
    n_cmp++; if (rom_req !== 1'b0) begin n_bad++; $display("FAIL rst_rom_req: got %b want 0", rom_req); end
    n_cmp++; if (sample_out !== 16'h0) begin n_bad++; $display("FAIL rst_sample: got %h want 0", sample_out); end
    n_cmp++; if ({new_sample_generated, busy, overrun} !== 3'b000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 000", {new_sample_generated, busy, overrun});
    end
  endtask

  task automatic test_all_disabled();
    voice_en = '0;
    run_frame(0);
    n_cmp++; if (pulse_cyc !== 5) begin n_bad++; $display("FAIL dis_pulse_cycle: got %0d want 5", pulse_cyc); end
    n_cmp++; if (samp !== 16'h0) begin n_bad++; $display("FAIL dis_sample: got %h want 0", samp); end
    n_cmp++; if (req_cnt !== 0) begin n_bad++; $display("FAIL dis_req_count: got %0d want 0", req_cnt); end
    n_cmp++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL dis_busy_c1: got %b want 1", busy_c1); end
  endtask

  task automatic test_single_voice();
    logic [15:0] exp_s;
    voice_en = 4'b0001;
    step_size = {20'h01000, 20'h01000, 20'h01000, 20'h01000};
    rom_const_mode = 1'b0;
    for (int f = 0; f < 3; f++) begin
      exp_s = SAT ? 16'(f) : 16'h0;
      run_frame(0);
      n_cmp++; if (req_cnt !== 1) begin n_bad++; $display("FAIL single_req_count f%0d: got %0d want 1", f, req_cnt); end
      n_cmp++; if (req_addr[0] !== AW'(f)) begin n_bad++; $display("FAIL single_addr f%0d: got %0d want %0d", f, req_addr[0], f); end
      n_cmp++; if (samp !== exp_s) begin n_bad++; $display("FAIL single_sample f%0d: got %h want %h", f, samp, exp_s); end
      n_cmp++; if (pulse_cyc !== 6) begin n_bad++; $display("FAIL single_pulse f%0d: got %0d want 6", f, pulse_cyc); end
    end
  endtask

  task automatic test_full_chord();
    logic [15:0] exp_s;
    voice_en = 4'b1111;
    rom_const_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rom_const = CH_VAL[k];
      exp_s = SAT ? CH_SATV[k] : CH_SHF[k];
      run_frame(0);
      n_cmp++; if (pulse_cyc !== 9) begin n_bad++; $display("FAIL chord_pulse k%0d: got %0d want 9", k, pulse_cyc); end
      n_cmp++; if (samp !== exp_s) begin n_bad++; $display("FAIL chord_sample k%0d: got %h want %h", k, samp, exp_s); end
      n_cmp++; if (req_cnt !== 4) begin n_bad++; $display("FAIL chord_req_count k%0d: got %0d want 4", k, req_cnt); end
      n_cmp++; if (req_addr[0] !== AW'(3 + k)) begin n_bad++; $display("FAIL chord_addr_v0 k%0d: got %0d want %0d", k, req_addr[0], 3 + k); end
      n_cmp++; if (req_addr[3] !== AW'(k)) begin n_bad++; $display("FAIL chord_addr_v3 k%0d: got %0d want %0d", k, req_addr[3], k); end
    end
    n_cmp++; if (sample_out !== (SAT ? CH_SATV[3] : CH_SHF[3])) begin
      n_bad++; $display("FAIL chord_hold: got %h want %h", sample_out, SAT ? CH_SATV[3] : CH_SHF[3]);
    end
  endtask

  task automatic test_reenable();
    logic [15:0] exp_s;
    voice_en = 4'b0010;
    rom_const_mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      run_frame(0);
      n_cmp++; if (req_addr[0] !== AW'(4 + k)) begin n_bad++; $display("FAIL reen_addr k%0d: got %0d want %0d", k, req_addr[0], 4 + k); end
    end
    exp_s = SAT ? 16'd8 : 16'd2;
    n_cmp++; if (samp !== exp_s) begin n_bad++; $display("FAIL reen_sample: got %h want %h", samp, exp_s); end
    voice_en = 4'b0000;
    run_frame(0);
    n_cmp++; if (req_cnt !== 0) begin n_bad++; $display("FAIL reen_off_reqs: got %0d want 0", req_cnt); end
    voice_en = 4'b0010;
    run_frame(0);
    n_cmp++; if (req_addr[0] !== AW'(0)) begin n_bad++; $display("FAIL reen_restart_addr: got %0d want 0", req_addr[0]); end
    n_cmp++; if (pulse_cyc !== 6) begin n_bad++; $display("FAIL reen_pulse: got %0d want 6", pulse_cyc); end
    run_frame(0);
    n_cmp++; if (req_addr[0] !== AW'(1)) begin n_bad++; $display("FAIL reen_second_addr: got %0d want 1", req_addr[0]); end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_s;
    voice_en = 4'b1111;
    rom_const_mode = 1'b1;
    rom_const = 16'h0100;
    exp_s = SAT ? 16'h0400 : 16'h0100;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_initial: got %b want 0", overrun); end
    run_frame(4);
    n_cmp++; if (pulse_cyc !== 9) begin n_bad++; $display("FAIL ovr_pulse: got %0d want 9", pulse_cyc); end
    n_cmp++; if (samp !== exp_s) begin n_bad++; $display("FAIL ovr_sample: got %h want %h", samp, exp_s); end
    n_cmp++; if (req_cnt !== 4) begin n_bad++; $display("FAIL ovr_req_count: got %0d want 4", req_cnt); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    run_frame(0);
    n_cmp++; if (pulse_cyc !== 9) begin n_bad++; $display("FAIL ovr_next_pulse: got %0d want 9", pulse_cyc); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_mid_reset();
    int pulses;
    voice_en = 4'b1111;
    rom_const_mode = 1'b1;
    rom_const = 16'h0100;
    @(posedge clk); #1 new_frame = 1'b1;
    @(posedge clk); #1 new_frame = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (rom_req !== 1'b1) begin n_bad++; $display("FAIL mrst_req_c5: got %b want 1", rom_req); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({rom_req, busy, new_sample_generated, overrun} !== 4'b0000) begin
      n_bad++; $display("FAIL mrst_flags: got %b want 0000", {rom_req, busy, new_sample_generated, overrun});
    end
    n_cmp++; if (sample_out !== 16'h0) begin n_bad++; $display("FAIL mrst_sample: got %h want 0", sample_out); end
    @(posedge clk); #1 reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (new_sample_generated) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mrst_no_pulse: got %0d want 0", pulses); end
    run_frame(0);
    n_cmp++; if (pulse_cyc !== 9) begin n_bad++; $display("FAIL mrst_fresh_pulse: got %0d want 9", pulse_cyc); end
    n_cmp++; if (req_addr[0] !== AW'(0) || req_addr[3] !== AW'(0)) begin
      n_bad++; $display("FAIL mrst_fresh_addr: got %0d/%0d want 0/0", req_addr[0], req_addr[3]);
    end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL mrst_overrun_clear: got %b want 0", overrun); end
    run_frame(9);
    n_cmp++; if (pulse_cyc !== 9) begin n_bad++; $display("FAIL done_cycle_pulse: got %0d want 9", pulse_cyc); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL done_cycle_overrun: got %b want 1", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_cycle_no_restart: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_all_disabled();
    test_single_voice();
    test_full_chord();
    test_reenable();
    test_overrun();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
